// File: rtl/abc_lane_ser_pkg.sv
// Shared types and helpers for the abc lane-bundle serializer.
// Imported by the interface, the lane mux and the serializer top.
package pa_Abc;

    localparam int ABC_LANE_W = 32;

    typedef logic [ABC_LANE_W-1:0] abc_lane_t;

    typedef enum logic {
        IDLE,
        SEND
    } abc_ser_st_e;

    // A single-lane bundle still needs a 1-bit index.
    function automatic int abc_idx_w(input int no1);
        return (no1 <= 1) ? 1 : $clog2(no1);
    endfunction

endpackage

// File: rtl/abc_lane_ser_if.sv
// Bundle-in / word-out handshake bus of abc_lane_ser.
// Optional out_par member is present when ABC_LANE_SER_PARITY_EN is defined.
interface abc_lane_ser_if
    import pa_Abc::*;
#(
    parameter int No1 = 6
);
    localparam int IdxW = abc_idx_w(No1);

    abc_lane_t [No1-1:0] abc;
    logic                in_vld;
    logic                in_rdy;
    abc_lane_t           out_data;
    logic [IdxW-1:0]     out_idx;
    logic                out_last;
    logic                out_vld;
    logic                out_rdy;
    logic                bsy;
`ifdef ABC_LANE_SER_PARITY_EN
    logic                out_par;
`endif

    // slave: the serializer; master: bundle producer plus word consumer.
    modport slave (
        input  abc, in_vld, out_rdy,
        output in_rdy, out_data, out_idx, out_last, out_vld, bsy
`ifdef ABC_LANE_SER_PARITY_EN
        , output out_par
`endif
    );

    modport master (
        output abc, in_vld, out_rdy,
        input  in_rdy, out_data, out_idx, out_last, out_vld, bsy
`ifdef ABC_LANE_SER_PARITY_EN
        , input out_par
`endif
    );

endinterface

// File: rtl/abc_lane_ser_mux.sv
// Purely combinational lane select: picks bundle_i[idx_i].
// Indices beyond No1-1 return zero so no X is produced for non power-of-2 bundles.
module abc_lane_mux
    import pa_Abc::*;
#(
    parameter int No1  = 6,
    parameter int IdxW = abc_idx_w(No1)
) (
    input  abc_lane_t [No1-1:0] bundle_i,
    input  logic [IdxW-1:0]     idx_i,
    output abc_lane_t           word_o
);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < No1; i++) begin
            if (idx_i == IdxW'(i)) word_o = bundle_i[i];
        end
    end

endmodule

// File: rtl/abc_lane_ser.sv
// Lane-bundle serializer: captures No1 x 32-bit lanes, streams them lane 0 first.
// Define ABC_LANE_SER_PARITY_EN to add the per-word even parity output out_par.
module abc_lane_ser
    import pa_Abc::*;
#(
    parameter int No1 = 6
) (
    input  logic           ck,
    input  logic           rst_n,
    abc_lane_ser_if.slave  bus
);

    localparam int              IdxW     = abc_idx_w(No1);
    localparam logic [IdxW-1:0] LAST_IDX = IdxW'(No1 - 1);

    abc_ser_st_e         st_q, st_d;
    logic [IdxW-1:0]     cnt_q, cnt_d;
    abc_lane_t [No1-1:0] bundle_q;
    abc_lane_t           word_w;
    logic                out_vld_w;
    logic                out_last_w;
    logic                in_rdy_w;
    logic                load_w;

    // Outputs are gated by rst_n so the reset cycle itself already looks idle.
    assign out_vld_w  = rst_n && (st_q == SEND);
    assign out_last_w = out_vld_w && (cnt_q == LAST_IDX);
    assign in_rdy_w   = rst_n && ((st_q == IDLE) || (out_last_w && bus.out_rdy));
    assign load_w     = bus.in_vld && in_rdy_w;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        unique case (st_q)
            IDLE: begin
                if (load_w) begin
                    st_d  = SEND;
                    cnt_d = '0;
                end
            end
            SEND: begin
                if (bus.out_rdy) begin
                    if (!out_last_w) begin
                        cnt_d = cnt_q + IdxW'(1);
                    end else begin
                        // A bundle captured on the last-word handshake streams without a bubble.
                        st_d  = load_w ? SEND : IDLE;
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the bundle store has no reset; it is only observable through out_vld-gated outputs.
    always_ff @(posedge ck) begin
        if (load_w) bundle_q <= bus.abc;
    end

    abc_lane_mux #(
        .No1  (No1),
        .IdxW (IdxW)
    ) u_mux (
        .bundle_i (bundle_q),
        .idx_i    (cnt_q),
        .word_o   (word_w)
    );

    assign bus.in_rdy   = in_rdy_w;
    assign bus.out_vld  = out_vld_w;
    assign bus.bsy      = out_vld_w;
    assign bus.out_last = out_last_w;
    assign bus.out_idx  = rst_n ? cnt_q : '0;
    assign bus.out_data = out_vld_w ? word_w : '0;

`ifdef ABC_LANE_SER_PARITY_EN
    logic [No1-1:0] par_q;

    // Parity is computed per lane at capture so the output path is a plain select.
    always_ff @(posedge ck) begin
        if (load_w) begin
            for (int i = 0; i < No1; i++) par_q[i] <= ^bus.abc[i];
        end
    end

    assign bus.out_par = out_vld_w ? par_q[cnt_q] : 1'b0;
`endif

endmodule

// File: doc/abc_lane_ser.md
Name: abc_lane_ser

Overview:
- Consumer end of the packed lane bus `abc` (logic [No1-1:0][31:0]) driven by Def-style producers.
- Captures one full lane bundle per valid/ready handshake.
- Streams the bundle out as one 32-bit word per cycle, lane 0 first, with its own valid/ready handshake.
- Sits between a bundle producer and any narrow 32-bit datapath (bus bridge, FIFO, debug port).

Parameters:
No1, 6, number of 32-bit lanes per bundle; legal range 1..64
IdxW, $clog2(No1) (min 1), width of the lane index output (derived, not overridden)

Ports:
ck       input   1            clock, all logic on rising edge
rst_n    input   1            synchronous active-low reset; one clock, sampled on ck
abc      input   [No1-1:0][31:0]  lane bundle, sampled when in_vld && in_rdy
in_vld   input   1            bundle valid
in_rdy   output  1            block can accept a bundle this cycle
out_data output  32           current lane word
out_idx  output  IdxW         lane index of out_data
out_last output  1            out_data is lane No1-1
out_vld  output  1            out_data/out_idx/out_last valid
out_rdy  input   1            downstream accepts word
bsy      output  1            bundle held or being streamed (= out_vld)

Behaviour:
- Reset (rst_n=0 at a ck edge):
  - State goes to IDLE.
  - out_vld=0, out_idx=0, out_last=0, out_data=0, in_rdy=0 during the reset cycle.
  - in_rdy=1 from the first cycle after rst_n=1.
- States:
  - IDLE:
    - in_rdy=1, out_vld=0.
    - On in_vld: capture abc into bundle register, lane counter=0 → SEND.
  - SEND:
    - out_vld=1, out_data=bundle[cnt], out_idx=cnt, out_last=(cnt==No1-1).
    - On out_rdy && !out_last: cnt++.
    - On out_rdy && out_last: bundle done → IDLE; or stay in SEND with cnt=0 if a new bundle is captured the same cycle.
- in_rdy:
  - IDLE: in_rdy=1.
  - SEND: in_rdy = out_last && out_rdy. This is a combinational path from out_rdy.
  - Back-to-back bundles therefore stream with zero bubbles: No1 words in No1 cycles when out_rdy stays 1.
- Latency: bundle accepted at edge N; lane 0 is presented with out_vld=1 in cycle N+1.
- Stall: while out_vld && !out_rdy, out_data, out_idx and out_last are held stable. abc is ignored while in_rdy=0.
- No1==1: out_last is always 1 in SEND and out_idx is always 0. Each bundle takes one cycle.
- Counter arithmetic:
  - cnt is IdxW bits and never exceeds No1-1.
  - It is cleared on capture, never wraps past No1-1, and is not a free-running counter.
- Reset mid-bundle: the remaining lanes are discarded with no partial flush. out_vld drops in the reset cycle.
- in_vld is not required to be held; if it drops before in_rdy, no capture happens.

Optional Feature:
- Macro: ABC_LANE_SER_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit) = ^out_data (even parity over the word), registered alongside the bundle.
  - Per-lane parity bits are computed at capture.
  - out_par is 0 at reset.
- Undefined:
  - Port and parity logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package pa_Abc:
  - Constant ABC_LANE_W=32.
  - Typedef abc_lane_t (logic [31:0]).
  - Enum abc_ser_st_e {IDLE, SEND}.
  - Function abc_idx_w(No1) for IdxW.
- Sub-module abc_lane_mux: a purely combinational lane select (bundle, idx → word).
  - It is the natural split, and it is reused by the verification model.
- All state stays in abc_lane_ser.

Test Plan:
- No1=6, lanes = 32'h1000_0000+i, in_vld one cycle, out_rdy=1 → out_data 0x10000000..0x10000005 on 6 consecutive cycles starting N+1; out_idx 0..5; out_last only on idx 5; in_rdy=1 again in the idx-5 cycle.
- Two bundles back-to-back (second has lanes 0xA0+i), in_vld held, out_rdy=1 → 12 words with no gap; second bundle is captured exactly on the idx-5 handshake.
- Stall: out_rdy=0 for 3 cycles at idx 2 → out_data, out_idx=2 and out_last=0 held constant; in_rdy=0; abc changed during the stall is not captured.
- Reset mid-bundle: rst_n=0 at idx 3 → next cycle out_vld=0, out_idx=0; after release, a new bundle streams from idx 0 with no stale lanes.
- No1=1: lane = 32'hDEAD_BEEF, continuous in_vld/out_rdy → one word per cycle, out_last=1 and out_idx=0 every cycle.
- ABC_LANE_SER_PARITY_EN defined: lane 32'h0000_0007 → out_par=1; lane 32'h0000_0003 → out_par=0; macro undefined build compiles without out_par.
